mdu_div_ctrl: RTL and testbench
===============================

Name: mdu_div_ctrl

Overview:
- Execute-stage front end for the multi-cycle radix-2 divider in the RV64 core.
- Accepts decoded DIV/DIVU/REM/REMU(W) requests from issue and resolves RISC-V special cases (divide-by-zero, signed overflow) locally in one cycle.
- For all other requests, drives the divider handshake, selects quotient or remainder, applies W-form sign extension, and returns a tagged, registered result to writeback with backpressure.

Parameters:
- XLEN, 64, datapath width.
- TAG_W, 5, destination-register tag width.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- flush, input, 1: pipeline kill; cancels any in-flight request.
- req_valid, input, 1: request present.
- req_ready, output, 1: controller can accept a request.
- req_funct3, input, 3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- req_w, input, 1: 32-bit W form.
- req_rs1, input, XLEN: dividend.
- req_rs2, input, XLEN: divisor.
- req_rd, input, TAG_W: destination tag.
- resp_valid, output, 1: result present.
- resp_ready, input, 1: writeback accepts the result.
- resp_data, output, XLEN: result.
- resp_rd, output, TAG_W: tag echoed from the request.
- div_valid, output, 1: operands valid to the divider.
- div_signed, output, 1: signed divide.
- divw, output, 1: 32-bit divide.
- dividend, output, XLEN: dividend to the divider.
- divisor, output, XLEN: divisor to the divider.
- div_flush, output, 1: cancel to the divider.
- div_ready, input, 1: divider idle.
- div_out_valid, input, 1: divider result valid, one-cycle pulse.
- div_quot, input, XLEN: divider quotient.
- div_rema, input, XLEN: divider remainder.

Behaviour:
- Reset is synchronous, active-high, on clk. Reset values:
  - State IDLE.
  - All outputs 0: resp_valid, resp_data, resp_rd, div_valid, div_flush, and all operand registers.
- Reset mid-operation abandons everything. The divider shares the same reset.
- States: IDLE, RUN, RESP, DRAIN.
- req_ready = (state==IDLE) && div_ready && !flush. Accept = req_valid && req_ready.
- On accept, register funct3, w, rs1, rs2 and rd, then evaluate special cases on the effective operands (low 32 bits when w):
  - Divisor zero: quotient = all ones; remainder = dividend.
  - Signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
  - If either applies: load resp_data, go to RESP. resp_valid is high the cycle after accept; the divider is never started.
  - Otherwise: go to RUN.
- RUN:
  - div_valid = 1; div_signed = !funct3[0]; divw = w.
  - dividend/divisor are driven from the operand registers and held stable for the whole RUN. The divider recomputes signs combinationally and needs them up to and including its out_valid cycle.
  - On div_out_valid: select div_quot (funct3[1]=0) or div_rema (funct3[1]=1). For w, replace bits 63:32 with bit 31 (also for DIVUW/REMUW). Register into resp_data; next state RESP.
  - div_valid is combinational from state, so it drops the cycle after out_valid. This prevents a relaunch.
- RESP:
  - resp_valid = 1; resp_data and resp_rd held stable until resp_ready.
  - On resp_ready: go to IDLE. A back-to-back accept is possible the following cycle.
- Flush handling (flush has priority over every other event in the same cycle):
  - IDLE: the request is ignored (req_ready is 0).
  - RESP: resp_valid drops next cycle; go to IDLE.
  - RUN: div_flush pulses 1 cycle and div_valid drops; go to DRAIN.
  - DRAIN: the divider cannot abort, so wait for div_out_valid, discard the result, then go to IDLE. req_ready stays 0 throughout. flush while in DRAIN is ignored.
- Latency: special case 1 cycle; normal case 1 + divider latency (~130 cycles). Benches must wait on handshakes, never fixed counts.
- Any funct3 with bit 2 = 0: accepted as no-op, resp_data = 0 (an assertion fires in simulation).

Decomposition:
- Shared package holds:
  - funct3 constants (FN_DIV, FN_DIVU, FN_REM, FN_REMU).
  - State encoding.
  - XLEN / TAG_W defaults.
  - A sign-extend-32 function.
- One combinational sub-module, mdu_div_special:
  - Inputs: funct3, w, rs1, rs2.
  - Outputs: is_special, special_result.
  - Unit-testable on its own.
- The FSM and result register live in mdu_div_ctrl.

Test Plan:
- DIV, rs1=100, rs2=-7 → resp_data 0xFFFFFFFFFFFFFFF2. REM with the same operands → 0x0000000000000002. resp_rd echoes 5'd9.
- DIVU, rs1=0x1234, rs2=0 → resp_valid 1 cycle after accept, data 0xFFFFFFFFFFFFFFFF, div_valid never high. REMU with the same operands → 0x1234.
- DIV (W), rs1=0x0000000080000000, rs2=0xFFFFFFFFFFFFFFFF → 0xFFFFFFFF80000000. REM (W) with the same operands → 0.
- DIVU (W), rs1=0x00000000FFFFFFFF, rs2=1 → 0xFFFFFFFFFFFFFFFF (sign-extended). REMU (W), rs1=7, rs2=2 → 1.
- DIV 7/2 flushed 10 cycles into RUN → div_flush pulse, no resp_valid, req_ready stays 0 until the divider's out_valid. Then a new DIV 7/2 → resp_data 3.
- DIV 7/2 with resp_ready held low for 5 cycles in RESP → resp_data=3 and resp_rd stable, req_ready=0. Accept completes on the first resp_ready.

Source files
------------

// File: rtl/mdu_div_ctrl_pkg.sv
// Shared types and helpers for the divider front end.
// Holds funct3 codes, FSM encoding and W-form sign extension.
package mdu_div_ctrl_pkg;

   localparam int XLEN_D  = 64;
   localparam int TAG_W_D = 5;

   localparam logic [2:0] FN_DIV  = 3'b100;
   localparam logic [2:0] FN_DIVU = 3'b101;
   localparam logic [2:0] FN_REM  = 3'b110;
   localparam logic [2:0] FN_REMU = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_RESP,
      ST_DRAIN
   } div_state_t;

   function automatic logic [XLEN_D-1:0] sext32(input logic [31:0] v);
      return {{(XLEN_D-32){v[31]}}, v};
   endfunction

endpackage

// File: rtl/mdu_div_special.sv
// RISC-V divide special cases: divide-by-zero, signed overflow,
// and non-divide funct3 codes, resolved without the divider.
module mdu_div_special
   import mdu_div_ctrl_pkg::*;
#(
   parameter int XLEN = XLEN_D
) (
   input  logic [2:0]      funct3,
   input  logic            w,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            is_special,
   output logic [XLEN-1:0] special_result
);

   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            is_signed;
   logic            is_rem;
   logic            min_a;
   logic            bad_op;
   logic            div0;
   logic            ovf;

   always_comb begin
      a         = w ? sext32(rs1[31:0]) : rs1;
      b         = w ? sext32(rs2[31:0]) : rs2;
      is_signed = !funct3[0];
      is_rem    = funct3[1];
      min_a     = w ? (rs1[31:0] == 32'h8000_0000)
                    : (rs1 == {1'b1, {(XLEN-1){1'b0}}});
      bad_op    = !funct3[2];
      div0      = funct3[2] && (b == '0);
      ovf       = funct3[2] && is_signed && min_a && (b == '1);
      is_special = bad_op || div0 || ovf;
   end

   // Conditions above are mutually exclusive by construction.
   always_comb begin
      special_result = '0;
      unique case (1'b1)
         bad_op:  special_result = '0;
         div0:    special_result = is_rem ? a : '1;
         ovf:     special_result = is_rem ? '0 : a;
         default: special_result = '0;
      endcase
   end

endmodule

// File: rtl/mdu_div_ctrl.sv
// Execute-stage divider front end: special-case bypass,
// divider handshake, result select and tagged writeback.
module mdu_div_ctrl
   import mdu_div_ctrl_pkg::*;
#(
   parameter int XLEN  = XLEN_D,
   parameter int TAG_W = TAG_W_D
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_funct3,
   input  logic             req_w,
   input  logic [XLEN-1:0]  req_rs1,
   input  logic [XLEN-1:0]  req_rs2,
   input  logic [TAG_W-1:0] req_rd,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [XLEN-1:0]  resp_data,
   output logic [TAG_W-1:0] resp_rd,
   output logic             div_valid,
   output logic             div_signed,
   output logic             divw,
   output logic [XLEN-1:0]  dividend,
   output logic [XLEN-1:0]  divisor,
   output logic             div_flush,
   input  logic             div_ready,
   input  logic             div_out_valid,
   input  logic [XLEN-1:0]  div_quot,
   input  logic [XLEN-1:0]  div_rema
);

   div_state_t      state;
   logic [1:0]      fn_q;
   logic            w_q;
   logic            accept;
   logic            is_special;
   logic [XLEN-1:0] special_result;
   logic [XLEN-1:0] sel;
   logic [XLEN-1:0] div_result;

   mdu_div_special #(.XLEN(XLEN)) u_special (
      .funct3         (req_funct3),
      .w              (req_w),
      .rs1            (req_rs1),
      .rs2            (req_rs2),
      .is_special     (is_special),
      .special_result (special_result)
   );

   assign req_ready  = (state == ST_IDLE) && div_ready && !flush;
   assign accept     = req_valid && req_ready;
   assign div_valid  = (state == ST_RUN);
   assign resp_valid = (state == ST_RESP);
   assign div_signed = !fn_q[0];
   assign divw       = w_q;

   always_comb begin
      sel        = fn_q[1] ? div_rema : div_quot;
      div_result = w_q ? sext32(sel[31:0]) : sel;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         fn_q      <= '0;
         w_q       <= 1'b0;
         dividend  <= '0;
         divisor   <= '0;
         resp_rd   <= '0;
         resp_data <= '0;
         div_flush <= 1'b0;
      end else begin
         div_flush <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  fn_q     <= req_funct3[1:0];
                  w_q      <= req_w;
                  dividend <= req_rs1;
                  divisor  <= req_rs2;
                  resp_rd  <= req_rd;
                  if (is_special) begin
                     resp_data <= special_result;
                     state     <= ST_RESP;
                  end else begin
                     state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               // A result landing with the flush leaves nothing to drain.
               if (flush) begin
                  state     <= div_out_valid ? ST_IDLE : ST_DRAIN;
                  div_flush <= !div_out_valid;
               end else if (div_out_valid) begin
                  resp_data <= div_result;
                  state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (flush || resp_ready) state <= ST_IDLE;
            end
            ST_DRAIN: begin
               if (div_out_valid) state <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && accept) assert (req_funct3[2]);
   end

endmodule

// File: tb/tb_mdu_div_ctrl.sv
// Directed bench for mdu_div_ctrl with a behavioural
// multi-cycle divider stand-in.
module tb_mdu_div_ctrl;

   localparam int DIV_LAT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_funct3;
   logic        req_w;
   logic [63:0] req_rs1;
   logic [63:0] req_rs2;
   logic [4:0]  req_rd;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_data;
   logic [4:0]  resp_rd;
   logic        div_valid;
   logic        div_signed;
   logic        divw;
   logic [63:0] dividend;
   logic [63:0] divisor;
   logic        div_flush;
   logic        div_ready;
   logic        div_out_valid;
   logic [63:0] div_quot;
   logic [63:0] div_rema;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mdu_div_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_funct3    (req_funct3),
      .req_w         (req_w),
      .req_rs1       (req_rs1),
      .req_rs2       (req_rs2),
      .req_rd        (req_rd),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_data     (resp_data),
      .resp_rd       (resp_rd),
      .div_valid     (div_valid),
      .div_signed    (div_signed),
      .divw          (divw),
      .dividend      (dividend),
      .divisor       (divisor),
      .div_flush     (div_flush),
      .div_ready     (div_ready),
      .div_out_valid (div_out_valid),
      .div_quot      (div_quot),
      .div_rema      (div_rema)
   );

   // Divider stand-in: cannot abort, recomputes from live operands.
   logic busy;
   int   cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= 1'b0;
         cnt  <= 0;
      end else if (!busy) begin
         if (div_valid) begin
            busy <= 1'b1;
            cnt  <= DIV_LAT;
         end
      end else if (cnt == 1) begin
         busy <= 1'b0;
      end else begin
         cnt <= cnt - 1;
      end
   end

   assign div_ready     = !busy;
   assign div_out_valid = busy && (cnt == 1);

   logic [63:0] ma, mb;
   always_comb begin
      ma = dividend;
      mb = divisor;
      if (divw) begin
         ma = div_signed ? {{32{dividend[31]}}, dividend[31:0]}
                         : {32'h0, dividend[31:0]};
         mb = div_signed ? {{32{divisor[31]}}, divisor[31:0]}
                         : {32'h0, divisor[31:0]};
      end
      div_quot = '1;
      div_rema = ma;
      if (mb == 64'h0) begin
         div_quot = '1;
         div_rema = ma;
      end else if (div_signed && mb == '1) begin
         div_quot = -ma;
         div_rema = '0;
      end else if (div_signed) begin
         div_quot = $signed(ma) / $signed(mb);
         div_rema = $signed(ma) % $signed(mb);
      end else begin
         div_quot = ma / mb;
         div_rema = ma % mb;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request, wait (bounded) for resp_valid; leaves resp pending.
   task automatic run_req(input logic [2:0] f, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, output int lat,
                          output logic saw_dv);
      @(negedge clk);
      req_valid  = 1'b1;
      req_funct3 = f;
      req_w      = w;
      req_rs1    = a;
      req_rs2    = b;
      req_rd     = rd;
      chk("req_ready_before_accept", req_ready, 1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat    = 1;
      saw_dv = 1'b0;
      @(negedge clk);
      saw_dv = saw_dv | div_valid;
      while (!resp_valid && lat < 400) begin
         @(negedge clk);
         saw_dv = saw_dv | div_valid;
         lat++;
      end
      chk("resp_timeout", resp_valid, 1);
   endtask

   task automatic take_resp();
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      @(negedge clk);
      chk("resp_drop", resp_valid, 0);
   endtask

   int   lat;
   logic dv;
   int   n;

   initial begin
      reset      = 1'b1;
      flush      = 1'b0;
      req_valid  = 1'b0;
      req_funct3 = 3'b000;
      req_w      = 1'b0;
      req_rs1    = '0;
      req_rs2    = '0;
      req_rd     = '0;
      resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_resp_rd", resp_rd, 0);
      chk("rst_div_valid", div_valid, 0);
      chk("rst_div_flush", div_flush, 0);
      chk("rst_dividend", dividend, 0);
      chk("rst_divisor", divisor, 0);
      chk("rst_req_ready", req_ready, 1);

      // DIV / REM 100 / -7
      run_req(3'b100, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd9, lat, dv);
      chk("div_data", resp_data, 64'hFFFF_FFFF_FFFF_FFF2);
      chk("div_rd", resp_rd, 5'd9);
      chk("div_used_divider", dv, 1);
      take_resp();
      run_req(3'b110, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd17, lat, dv);
      chk("rem_data", resp_data, 64'h2);
      chk("rem_rd", resp_rd, 5'd17);
      take_resp();

      // Divide by zero: one cycle, divider untouched
      run_req(3'b101, 1'b0, 64'h1234, 64'h0, 5'd3, lat, dv);
      chk("divu0_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("divu0_lat", lat, 1);
      chk("divu0_no_div_valid", dv, 0);
      take_resp();
      run_req(3'b111, 1'b0, 64'h1234, 64'h0, 5'd4, lat, dv);
      chk("remu0_data", resp_data, 64'h1234);
      chk("remu0_lat", lat, 1);
      take_resp();

      // W-form signed overflow
      run_req(3'b100, 1'b1, 64'h0000_0000_8000_0000,
              64'hFFFF_FFFF_FFFF_FFFF, 5'd5, lat, dv);
      chk("divw_ovf_data", resp_data, 64'hFFFF_FFFF_8000_0000);
      chk("divw_ovf_lat", lat, 1);
      chk("divw_ovf_no_div_valid", dv, 0);
      take_resp();
      run_req(3'b110, 1'b1, 64'h0000_0000_8000_0000,
              64'hFFFF_FFFF_FFFF_FFFF, 5'd6, lat, dv);
      chk("remw_ovf_data", resp_data, 64'h0);
      take_resp();

      // W-form unsigned through the divider, sign-extended result
      run_req(3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h1, 5'd7, lat, dv);
      chk("divuw_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("divuw_used_divider", dv, 1);
      take_resp();
      run_req(3'b111, 1'b1, 64'd7, 64'd2, 5'd8, lat, dv);
      chk("remuw_data", resp_data, 64'h1);
      take_resp();

      // Flush ten cycles into RUN
      @(negedge clk);
      req_valid  = 1'b1;
      req_funct3 = 3'b100;
      req_w      = 1'b0;
      req_rs1    = 64'd7;
      req_rs2    = 64'd2;
      req_rd     = 5'd11;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (10) @(negedge clk);
      chk("flush_in_run", div_valid, 1);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_div_flush_pulse", div_flush, 1);
      chk("flush_div_valid_drop", div_valid, 0);
      chk("flush_req_ready_drain", req_ready, 0);
      @(negedge clk);
      chk("flush_div_flush_end", div_flush, 0);
      n  = 0;
      dv = 1'b0;
      while (!div_out_valid && n < 400) begin
         dv = dv | resp_valid | req_ready;
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", div_out_valid, 1);
      chk("drain_no_resp_no_ready", dv, 0);
      chk("drain_ready_at_out_valid", req_ready, 0);
      @(negedge clk);
      chk("drain_done_ready", req_ready, 1);
      chk("drain_no_resp", resp_valid, 0);

      run_req(3'b100, 1'b0, 64'd7, 64'd2, 5'd12, lat, dv);
      chk("post_flush_div_data", resp_data, 64'd3);
      chk("post_flush_div_rd", resp_rd, 5'd12);
      take_resp();

      // Writeback backpressure for five cycles
      run_req(3'b100, 1'b0, 64'd7, 64'd2, 5'd21, lat, dv);
      for (int i = 0; i < 5; i++) begin
         chk("bp_resp_valid", resp_valid, 1);
         chk("bp_resp_data", resp_data, 64'd3);
         chk("bp_resp_rd", resp_rd, 5'd21);
         chk("bp_req_ready", req_ready, 0);
         @(negedge clk);
      end
      take_resp();
      chk("bp_back_to_back_ready", req_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
